// File: rtl/logicunit_packer.sv
// Packs a serial stream of logicunit result bits into WIDTH-bit words, each word
// tagged with the single control value that produced all of its bits.
module logicunit_packer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       in_control,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_count,
  output logic [1:0]       out_control
);

  localparam logic [4:0] FULL = 5'(WIDTH);

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    CLOSE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, acc_masked;
  logic [4:0]       cnt, cnt_n;
  logic [1:0]       acc_ctrl, ctrl_n;
  logic             flush_pend, fp_n;
  logic             slot_free, mismatch, accept, load;

  assign slot_free = !out_valid || out_ready;
  assign mismatch  = (in_control != acc_ctrl);

  always_comb begin
    acc_masked = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (5'(i) < cnt) acc_masked[i] = acc[i];
    end
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    ctrl_n   = acc_ctrl;
    fp_n     = flush_pend;
    in_ready = 1'b1;
    accept   = 1'b0;
    load     = 1'b0;

    case (state)
      FILL:    in_ready = !(mismatch && !slot_free);
      CLOSE:   in_ready = 1'b0;
      default: in_ready = 1'b1;
    endcase

    accept = in_valid && in_ready;

    case (state)
      EMPTY: begin
        if (accept) begin
          acc_n    = '0;
          acc_n[0] = in_bit;
          cnt_n    = 5'd1;
          ctrl_n   = in_control;
          fp_n     = flush;
        end
      end
      FILL: begin
        // A control change hands the partial word off and restarts in one cycle.
        if (accept && mismatch) begin
          load     = 1'b1;
          acc_n    = '0;
          acc_n[0] = in_bit;
          cnt_n    = 5'd1;
          ctrl_n   = in_control;
          fp_n     = flush;
        end else begin
          if (accept) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
              if (5'(i) == cnt) acc_n[i] = in_bit;
            end
            cnt_n = cnt + 5'd1;
          end
          if (flush) fp_n = 1'b1;
        end
      end
      CLOSE: begin
        if (slot_free) begin
          load  = 1'b1;
          cnt_n = '0;
          fp_n  = 1'b0;
        end
      end
      default: begin
        cnt_n = '0;
        fp_n  = 1'b0;
      end
    endcase

    if (cnt_n == '0)                  state_n = EMPTY;
    else if (cnt_n == FULL || fp_n)   state_n = CLOSE;
    else                              state_n = FILL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      acc         <= '0;
      cnt         <= '0;
      acc_ctrl    <= '0;
      flush_pend  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
      out_control <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      acc_ctrl   <= ctrl_n;
      flush_pend <= fp_n;
      if (load) begin
        out_valid   <= 1'b1;
        out_data    <= acc_masked;
        out_count   <= cnt;
        out_control <= acc_ctrl;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/logicunit_packer.md
LOGICUNIT_PACKER -- requirements
Module: logicunit_packer

Interface
REQ-001 SHALL have one parameter: WIDTH, default 8, bits per packed word (legal 2..16).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 SHALL have port in_valid, input, 1, upstream logicunit result bit valid this cycle.
REQ-005 SHALL have port in_bit, input, 1, logicunit out bit.
REQ-006 SHALL have port in_control, input, 2, logicunit control used to produce in_bit.
REQ-007 SHALL have port in_ready, output, 1, packer accepts a bit this cycle; combinational, never a function of in_valid.
REQ-008 SHALL have port flush, input, 1, close any partial word.
REQ-009 SHALL have port out_valid, output, 1, packed word available.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes word.
REQ-011 SHALL have port out_data, output, WIDTH, packed bits, LSB = first accepted bit, unused upper bits 0.
REQ-012 SHALL have port out_count, output, 5, number of valid bits in out_data (1..WIDTH).
REQ-013 SHALL have port out_control, output, 2, control value shared by every bit of the word.

Function
REQ-014 SHALL hold an accumulator acc[WIDTH], bit count cnt (0..WIDTH), acc_ctrl[2], flush_pend flag, plus one output register set (out_*).
REQ-015 SHALL operate states EMPTY (cnt=0), FILL (0<cnt<WIDTH, flush_pend=0), CLOSE (cnt=WIDTH or flush_pend=1 with cnt>0).
REQ-016 SHALL accept a bit when in_valid and in_ready are both 1: acc[cnt] <= in_bit, cnt <= cnt+1; in EMPTY also acc_ctrl <= in_control.
REQ-017 SHALL drive in_ready = 1 in EMPTY and FILL, 0 in CLOSE, and 0 in FILL when in_control != acc_ctrl while out_valid=1 and out_ready=0 (mismatch stall).
REQ-018 SHALL, in FILL with an accepted bit whose in_control != acc_ctrl, move the partial word to the output register and start a new word (acc[0] = in_bit, cnt = 1, acc_ctrl = in_control) in the same cycle.
REQ-019 SHALL, in CLOSE, move acc to the output register (out_data = acc with bits >= cnt zeroed, out_count = cnt, out_control = acc_ctrl) in the first cycle the output slot is free, then return to EMPTY with flush_pend = 0.
REQ-020 SHALL treat the output slot as free when out_valid = 0 or out_ready = 1 (simultaneous consume and load allowed, no bubble).
REQ-021 SHALL set out_valid on load and clear it on consume without load; out_* SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL set flush_pend on flush when cnt>0 or a bit is accepted that cycle (that bit is included); flush with cnt=0 and no accept SHALL have no effect.
REQ-023 SHALL reach CLOSE on the cycle after the WIDTH-th bit is accepted; full-word throughput is WIDTH words bits per WIDTH+1 cycles.
REQ-024 SHALL have latency of exactly 1 cycle from entering CLOSE to out_valid=1 when the output slot is free.

Reset
REQ-025 SHALL, while reset=0, force cnt=0, acc=0, acc_ctrl=0, flush_pend=0, out_valid=0, out_data=0, out_count=0, out_control=0, in_ready=1, independent of clk.
REQ-026 SHALL discard any partial or pending word on reset assertion mid-operation; no word is emitted afterward for it.
REQ-027 SHALL accept a bit on the first rising edge after reset returns to 1.

Verification
REQ-028 Full word: control=0, 8 bits 1,0,1,1,0,0,1,0 back-to-back, out_ready=1 -> out_data=8'h4D, out_count=8, out_control=0, in_ready low exactly 1 cycle.
REQ-029 Control change: 3 bits 1,1,1 at control=1 then bit 0 at control=2 -> word 8'h07, count 3, control 1; next word starts with count 1, control 2.
REQ-030 Backpressure: out_ready=0, two full words at control=3 -> first word held stable, in_ready=0 in CLOSE of second; both emitted in order once out_ready=1.
REQ-031 Flush: 5 bits 1,1,0,0,1 at control=0, flush with 5th bit -> out_data=8'h13, out_count=5; flush when EMPTY -> no output.
REQ-032 Reset mid-word: 4 bits accepted, reset=0 for 1 cycle between edges -> all outputs 0 immediately, no partial word emitted, next word starts at bit 0.
REQ-033 Mismatch stall: out_valid=1, out_ready=0, FILL, in_control differs -> in_ready=0, no acc change until out_ready=1.
